// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers the operands, stage 2 holds the result and flags.
// Valid/ready on both sides, flush, and illegal-opcode reporting.
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal_op,
    output logic             z,
    output logic             n,
    output logic             v
);

    typedef enum logic [3:0] {
        OpAdd    = 4'd0,
        OpSub    = 4'd1,
        OpXor    = 4'd2,
        OpRed    = 4'd3,
        OpSll    = 4'd4,
        OpSra    = 4'd5,
        OpRor    = 4'd6,
        OpPaddsb = 4'd7,
        OpLw     = 4'd8,
        OpSw     = 4'd9
    } op_e;

    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] sext8(input logic [7:0] x);
        return {{(WIDTH-8){x[7]}}, x};
    endfunction

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [SHW-1:0]   s1_imm_q, s1_imm_d;

    // Stage 2 state and flag file
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             illegal_q, illegal_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;

    logic adv2;

    assign adv2     = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv2;

    // Stage 2 datapath, combinational from the stage-1 registers
    logic [WIDTH-1:0] sum, diff, red_sum, paddsb, sll, sra, ror, addr;
    logic             add_ovf, sub_ovf;
    logic [4:0]       lane;
    logic [WIDTH-1:0] calc_res;
    logic             calc_ill, calc_ovf, upd_nzv, upd_z;

    assign sum     = s1_a_q + s1_b_q;
    assign diff    = s1_a_q - s1_b_q;
    assign add_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
    assign sub_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
    assign sll     = s1_a_q << s1_imm_q;
    assign sra     = $signed(s1_a_q) >>> s1_imm_q;
    // A shift by WIDTH yields zero, so imm == 0 degenerates to a plain copy.
    assign ror     = (s1_a_q >> s1_imm_q) | (s1_a_q << (WIDTH - 32'(s1_imm_q)));
    assign addr    = {s1_a_q[WIDTH-1:1], 1'b0} + s1_b_q;

    always_comb begin
        red_sum = '0;
        for (int i = 0; i < int'(WIDTH / 8); i++) begin
            red_sum = red_sum + sext8(s1_a_q[8*i +: 8]) + sext8(s1_b_q[8*i +: 8]);
        end
    end

    always_comb begin
        paddsb = '0;
        lane   = '0;
        for (int i = 0; i < int'(WIDTH / 4); i++) begin
            lane = {s1_a_q[4*i+3], s1_a_q[4*i +: 4]} + {s1_b_q[4*i+3], s1_b_q[4*i +: 4]};
            if (lane[4] != lane[3]) begin
                paddsb[4*i +: 4] = lane[4] ? 4'h8 : 4'h7;
            end else begin
                paddsb[4*i +: 4] = lane[3:0];
            end
        end
    end

    always_comb begin
        calc_res = '0;
        calc_ill = 1'b0;
        calc_ovf = 1'b0;
        upd_nzv  = 1'b0;
        upd_z    = 1'b0;
        case (s1_op_q)
            OpAdd: begin
                calc_res = add_ovf ? (s1_a_q[WIDTH-1] ? MinNeg : MaxPos) : sum;
                calc_ovf = add_ovf;
                upd_nzv  = 1'b1;
            end
            OpSub: begin
                calc_res = sub_ovf ? (s1_a_q[WIDTH-1] ? MinNeg : MaxPos) : diff;
                calc_ovf = sub_ovf;
                upd_nzv  = 1'b1;
            end
            OpXor: begin
                calc_res = s1_a_q ^ s1_b_q;
                upd_z    = 1'b1;
            end
            OpRed:    calc_res = red_sum;
            OpSll: begin
                calc_res = sll;
                upd_z    = 1'b1;
            end
            OpSra: begin
                calc_res = sra;
                upd_z    = 1'b1;
            end
            OpRor: begin
                calc_res = ror;
                upd_z    = 1'b1;
            end
            OpPaddsb: calc_res = paddsb;
            OpLw, OpSw: calc_res = addr;
            default:  calc_ill = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_imm_d    = s1_imm_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (adv2) begin
                out_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    result_d  = calc_res;
                    illegal_d = calc_ill;
                    if (upd_nzv || upd_z) begin
                        z_d = (calc_res == '0);
                    end
                    if (upd_nzv) begin
                        n_d = calc_res[WIDTH-1];
                        v_d = calc_ovf;
                    end
                end
            end
            if (in_ready) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_op_d  = opcode;
                    s1_a_d   = a;
                    s1_b_d   = b;
                    s1_imm_d = imm;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_imm_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_imm_q    <= s1_imm_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign illegal_op = illegal_q;
    assign z          = z_q;
    assign n          = n_q;
    assign v          = v_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle 16-bit datapath ALU.
- Same opcode set: ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB, LW/SW address.
- Adds generalised word width, valid/ready handshakes on both sides, a registered flag file with per-opcode update masks, flush, and illegal-opcode detection.
- Sits between the decode/operand-read stage and the writeback/memory stage; backpressure comes from downstream stalls.

Parameters:
- WIDTH, 16, datapath width in bits; must be a multiple of 8 and ≥ 16.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous; drops all in-flight ops.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage 1 can accept.
- opcode  in  4  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B / address offset.
- imm  in  SHW  shift/rotate amount.
- out_valid  out  1  result held in stage 2.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  stage 2 result.
- illegal_op  out  1  stage 2 op had an undefined opcode.
- z, n, v  out  1 each  registered flag file.

Behaviour:
- Reset (rst_n=0 at a clk edge): s1_valid=0, out_valid=0, result=0, illegal_op=0, z=n=v=0.
- Reset has priority over flush; flush has priority over all transfers.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - adv2 = !out_valid || out_ready.
  - in_ready = !s1_valid || adv2, combinational.
  - Full throughput: one op per cycle when out_ready is held high.
  - Latency is 2 cycles: op accepted at edge k is visible on result/out_valid after edge k+1.
- Stage 1 registers opcode, a, b and imm.
- Stage 2 computes combinationally from the stage-1 registers and loads result, illegal_op and out_valid on adv2.
- If s1_valid=0 on adv2, out_valid clears and result holds its value.
- result and illegal_op are stable while out_valid && !out_ready.
- Opcodes (all widths WIDTH):
  - 0 ADD: signed saturating add.
  - 1 SUB: signed saturating a−b. Overflow in either direction clamps to 0x7F..F or 0x80..0.
  - 2 XOR: a^b.
  - 3 RED: signed sum of every byte of a and every byte of b, sign-extended to WIDTH. Never overflows at any legal WIDTH.
  - 4 SLL: shift left by imm.
  - 5 SRA: arithmetic shift right by imm.
  - 6 ROR: rotate right by imm.
  - 7 PADDSB: independent signed saturating add per 4-bit lane.
  - 8 LW / 9 SW: (a & ~1) + b, wrapping, no saturation.
  - 10–15: result=0, illegal_op=1.
- Flag update happens on the same edge the result is loaded into stage 2, only for a valid op:
  - ADD/SUB update n=result MSB, z=(result==0), v=1 iff saturation occurred.
  - XOR/SLL/SRA/ROR update z only.
  - RED, PADDSB, LW, SW and illegal opcodes leave all flags unchanged.
- Flags are never rewritten by a stalled op held in stage 2.
- Flush:
  - Clears s1_valid and out_valid next edge; any op input-transferred that same cycle is discarded.
  - Flags already written remain; flags from a discarded op never update.
- Simultaneous output transfer and new load in one cycle is legal; no bubble is inserted.

Test Plan:
- WIDTH=16, ADD a=0x7FFF b=0x0001 → result 0x7FFF, v=1 n=0 z=0, out_valid 2 edges after accept.
- SUB a=0x8000 b=0x0001 → 0x8000, v=1 n=1. Then XOR a=b=0x1234 → 0x0000, z=1, while n=1 and v=1 are retained.
- out_ready=0, issue ADDs 1+1, 2+2, 3+3 back-to-back:
  - in_ready drops after two accepts; result holds 0x0002.
  - Release out_ready → 0x0002, 0x0004, 0x0006 delivered in order with no loss or duplication.
- RED a=0x7F7F b=0x7F7F → 0x01FC. PADDSB a=0x7777 b=0x1111 → 0x7777. Neither changes z/n/v.
- ROR a=0x8001 imm=1 → 0xC000, z=0. SRA 0x8000 imm=15 → 0xFFFF. LW a=0x1003 b=0x0004 → 0x1006. Opcode 0xF → 0x0000, illegal_op=1, flags unchanged.
- Two ops in flight, then flush=1 for one cycle:
  - out_valid=0 next edge, no flag change.
  - Repeat with rst_n=0 instead → all outputs 0.
  - Rerun the overflow scenario at WIDTH=32: 0x7FFFFFFF+1 → 0x7FFFFFFF, v=1.
